bcd_serial_add_ctrl: RTL and testbench
======================================

BCD_SERIAL_ADD_CTRL -- requirements
Module: bcd_serial_add_ctrl

Interface
REQ-001 Parameter DIGITS, default 4, meaning: number of BCD digits per operand (range 1..8).
REQ-002 Clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to add; sampled only in IDLE.
REQ-005 X  input  4*DIGITS  operand A, packed BCD, digit 0 in bits [3:0].
REQ-006 Y  input  4*DIGITS  operand B, packed BCD.
REQ-007 cin  input  1  carry into digit 0.
REQ-008 op  input  1  0 = add, 1 = subtract (present only when BCD_SUB_EN is defined).
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 S  output  4*DIGITS  packed BCD result.
REQ-012 cout  output  1  carry out of the top digit; in subtract mode, 1 = no borrow.
REQ-013 err  output  1  an operand held a digit greater than 9.

Function
REQ-014 The FSM SHALL have the states IDLE, CHECK, ADD, DONE.
REQ-015 In IDLE with start=1, the edge SHALL latch X, Y, cin (and op) into internal registers and move to CHECK.
REQ-016 In CHECK, if any latched digit is greater than 9, the FSM SHALL go to DONE with err=1, S=0, cout=0; otherwise it SHALL go to ADD with digit index 0 and carry register = latched cin.
REQ-017 In ADD, each cycle SHALL add exactly one digit pair plus the carry register, write the 4-bit BCD sum to S digit [index], update the carry, and increment the index.
REQ-018 A digit sum greater than 9 SHALL be corrected by +6 and SHALL produce carry 1.
REQ-019 After digit DIGITS-1, the FSM SHALL go to DONE with cout = final carry.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 Latency: done SHALL go high DIGITS+2 cycles after the accepting edge on a valid add, and 2 cycles after it on err.
REQ-022 start while busy=1 SHALL be ignored; operand changes during an operation SHALL have no effect.
REQ-023 S, cout and err SHALL hold their values from DONE until the next accepted start, which SHALL clear them.
REQ-024 start held high continuously SHALL start a new operation on the first IDLE cycle after DONE.

Reset
REQ-025 Reset=1 SHALL force IDLE, busy=0, done=0, S=0, cout=0, err=0, index=0, carry=0, taking priority over start.
REQ-026 Reset asserted mid-operation SHALL abandon the operation with no done pulse.

Configuration
REQ-027 Macro BCD_SUB_EN defined: the op port SHALL exist. When op=1 latched, Y SHALL be replaced digit-wise by its nine's complement in ADD, with initial carry = 1 and cin ignored. Validity checking SHALL use the original Y.
REQ-028 Macro BCD_SUB_EN undefined: the op port and all subtract logic SHALL be absent; behaviour is add-only.

Structure
REQ-029 Package bcd_pkg SHALL hold the state enum typedef, DIGIT_W=4, BCD_MAX=9 and BCD_ADJ=6.
REQ-030 A combinational sub-module bcd_digit_add (a, b, ci -> s, co) SHALL be instantiated once and time-shared across digits.

Verification (DIGITS=4)
REQ-031 X=9999, Y=0001, cin=0 -> S=0000, cout=1, err=0, done exactly 6 cycles after accept.
REQ-032 X=1234, Y=5678, cin=1 -> S=6913, cout=0.
REQ-033 X=12A4, Y=0000 -> err=1, S=0000, cout=0, done 2 cycles after accept; no ADD cycles.
REQ-034 start pulsed during ADD with new operands -> ignored; the result matches the first operands and exactly one done pulse occurs.
REQ-035 Reset during the second ADD cycle -> next cycle IDLE with all outputs 0 and no done; a following start runs correctly.
REQ-036 With BCD_SUB_EN: X=1000, Y=0001, op=1 -> S=0999, cout=1; X=0001, Y=0002, op=1 -> S=9999, cout=0.

Source files
------------

// File: rtl/bcd_serial_add_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the serial BCD adder controller.
//   - state_t  : controller FSM states
//   - DIGIT_W  : bits per BCD digit
//   - BCD_MAX  : largest legal BCD digit value
//   - BCD_ADJ  : decimal adjust applied when a digit sum exceeds BCD_MAX
//   - digit_bad()  : flags a nibble that is not a legal BCD digit
//   - nines_comp() : nine's complement of one BCD digit (used for subtract)
// Optional feature macro used elsewhere in this block: BCD_SUB_EN.
// ---------------------------------------------------------------------------
package bcd_pkg;

    localparam int         DIGIT_W = 4;
    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_ADD   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic digit_bad(input logic [3:0] d);
        return (d > BCD_MAX);
    endfunction

    function automatic logic [3:0] nines_comp(input logic [3:0] d);
        return (BCD_MAX - d);
    endfunction

endpackage

// File: rtl/bcd_serial_add_ctrl_if.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl_if
// Request/result bundle of the serial BCD adder.
//   i_start        : request an operation (looked at only while idle)
//   i_x, i_y       : packed BCD operands, digit 0 in bits [3:0]
//   i_cin          : carry into digit 0
//   i_op           : 0 = add, 1 = subtract (only with BCD_SUB_EN defined)
//   o_busy         : controller is not idle
//   o_done         : one-cycle completion pulse
//   o_s            : packed BCD result
//   o_cout         : carry out of the top digit (subtract: 1 = no borrow)
//   o_err          : an operand held a digit greater than 9
// Modports: master drives the request, slave is the adder controller.
// ---------------------------------------------------------------------------
interface bcd_serial_add_ctrl_if #(parameter int DIGITS = 4);
    import bcd_pkg::*;

    logic                       i_start;
    logic [DIGIT_W*DIGITS-1:0]  i_x;
    logic [DIGIT_W*DIGITS-1:0]  i_y;
    logic                       i_cin;
`ifdef BCD_SUB_EN
    logic                       i_op;
`endif
    logic                       o_busy;
    logic                       o_done;
    logic [DIGIT_W*DIGITS-1:0]  o_s;
    logic                       o_cout;
    logic                       o_err;

    modport master (
`ifdef BCD_SUB_EN
        output i_op,
`endif
        output i_start, i_x, i_y, i_cin,
        input  o_busy, o_done, o_s, o_cout, o_err
    );

    modport slave (
`ifdef BCD_SUB_EN
        input  i_op,
`endif
        input  i_start, i_x, i_y, i_cin,
        output o_busy, o_done, o_s, o_cout, o_err
    );

endinterface

// File: rtl/bcd_serial_add_ctrl_digit_add.sv
// ---------------------------------------------------------------------------
// bcd_digit_add
// Combinational single-digit BCD adder: s/co = a + b + ci, decimal adjusted.
//   i_a, i_b : BCD digits (0..9)
//   i_ci     : carry in
//   o_s      : BCD sum digit
//   o_co     : decimal carry out
// ---------------------------------------------------------------------------
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_ci,
    output logic [3:0] o_s,
    output logic       o_co
);

    logic [4:0] w_sum;

    // Binary sum, then +6 adjust when the result leaves the decimal range;
    // the adjust wraps the low nibble back into 0..9 (max input sum is 19).
    always_comb begin
        w_sum = {1'b0, i_a} + {1'b0, i_b} + {4'b0000, i_ci};
        if (w_sum > {1'b0, BCD_MAX}) begin
            o_s  = w_sum[3:0] + BCD_ADJ;
            o_co = 1'b1;
        end else begin
            o_s  = w_sum[3:0];
            o_co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_serial_add_ctrl
// Digit-serial BCD adder controller. One digit pair is processed per cycle
// through a single shared bcd_digit_add instance.
// Flow: IDLE -(start)-> CHECK -> ADD x DIGITS -> DONE -> IDLE
//       CHECK jumps straight to DONE with o_err=1 on an illegal digit.
// Ports:
//   i_clk : clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : bcd_serial_add_ctrl_if.slave (request and result signals)
// Parameter DIGITS : BCD digits per operand (1..8).
// Macro BCD_SUB_EN : adds i_op; op=1 computes X - Y via nine's complement.
// ---------------------------------------------------------------------------
module bcd_serial_add_ctrl
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    bcd_serial_add_ctrl_if.slave    bus
);

    localparam int W     = DIGIT_W * DIGITS;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [W-1:0]       r_x;
    logic [W-1:0]       r_y;
    logic [W-1:0]       r_s;
    logic               r_cin;
    logic               r_carry;
    logic               r_cout;
    logic               r_err;
    logic [IDX_W-1:0]   r_idx;
`ifdef BCD_SUB_EN
    logic               r_op;
`endif
    logic               w_bad;
    logic               w_last;
    logic               w_carry_init;
    logic [3:0]         w_a;
    logic [3:0]         w_b;
    logic [3:0]         w_sum;
    logic               w_co;

    // Validity scan of the latched operands (original Y, before complement).
    always_comb begin
        w_bad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (digit_bad(r_x[i*DIGIT_W +: DIGIT_W]) || digit_bad(r_y[i*DIGIT_W +: DIGIT_W])) begin
                w_bad = 1'b1;
            end else begin
                w_bad = w_bad;
            end
        end
    end

    // Digit operand selection and first-digit carry.
    always_comb begin
        w_a    = r_x[r_idx*DIGIT_W +: DIGIT_W];
        w_last = (r_idx == IDX_W'(DIGITS - 1));
`ifdef BCD_SUB_EN
        if (r_op) begin
            w_b          = nines_comp(r_y[r_idx*DIGIT_W +: DIGIT_W]);
            w_carry_init = 1'b1;
        end else begin
            w_b          = r_y[r_idx*DIGIT_W +: DIGIT_W];
            w_carry_init = r_cin;
        end
`else
        w_b          = r_y[r_idx*DIGIT_W +: DIGIT_W];
        w_carry_init = r_cin;
`endif
    end

    bcd_digit_add u_digit_add (
        .i_a  (w_a),
        .i_b  (w_b),
        .i_ci (r_carry),
        .o_s  (w_sum),
        .o_co (w_co)
    );

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.i_start) w_state_nxt = ST_CHECK;
                else             w_state_nxt = ST_IDLE;
            end
            ST_CHECK: begin
                if (w_bad) w_state_nxt = ST_DONE;
                else       w_state_nxt = ST_ADD;
            end
            ST_ADD: begin
                if (w_last) w_state_nxt = ST_DONE;
                else        w_state_nxt = ST_ADD;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Operand capture, digit-serial accumulation and result registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_cin   <= 1'b0;
`ifdef BCD_SUB_EN
            r_op    <= 1'b0;
`endif
            r_s     <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b0;
            r_idx   <= '0;
            r_carry <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_start) begin
                        r_x     <= bus.i_x;
                        r_y     <= bus.i_y;
                        r_cin   <= bus.i_cin;
`ifdef BCD_SUB_EN
                        r_op    <= bus.i_op;
`endif
                        r_s     <= '0;
                        r_cout  <= 1'b0;
                        r_err   <= 1'b0;
                        r_idx   <= '0;
                        r_carry <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (w_bad) begin
                        r_err  <= 1'b1;
                        r_s    <= '0;
                        r_cout <= 1'b0;
                    end else begin
                        r_idx   <= '0;
                        r_carry <= w_carry_init;
                    end
                end
                ST_ADD: begin
                    r_s[r_idx*DIGIT_W +: DIGIT_W] <= w_sum;
                    r_carry <= w_co;
                    if (w_last) begin
                        r_cout <= w_co;
                        r_idx  <= '0;
                    end else begin
                        r_idx  <= r_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_idx <= r_idx;
                end
            endcase
        end
    end

    assign bus.o_busy = (r_state != ST_IDLE);
    assign bus.o_done = (r_state == ST_DONE);
    assign bus.o_s    = r_s;
    assign bus.o_cout = r_cout;
    assign bus.o_err  = r_err;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_serial_add_ctrl
// Directed bench for bcd_serial_add_ctrl with DIGITS=4: a vector table of
// operands with hand-computed sums, plus sequences for start-while-busy,
// start held high and reset in the middle of an addition.
// Latency is counted in cycles after the accepting edge, the cycle right
// after that edge being cycle 1; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_bcd_serial_add_ctrl;

    localparam int DIGITS = 4;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
        logic        cin;
        logic        op;
        logic [15:0] s;
        logic        cout;
        logic        err;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errs   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    bcd_serial_add_ctrl_if #(.DIGITS(DIGITS)) bus ();

    bcd_serial_add_ctrl #(.DIGITS(DIGITS)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    function automatic vec_t mk(input logic [15:0] x, input logic [15:0] y, input logic cin,
                                input logic op, input logic [15:0] s, input logic cout,
                                input logic err, input int lat);
        vec_t v;
        v.x = x; v.y = y; v.cin = cin; v.op = op;
        v.s = s; v.cout = cout; v.err = err; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [15:0] x, input logic [15:0] y, input logic cin, input logic op);
        bus.i_x   = x;
        bus.i_y   = y;
        bus.i_cin = cin;
`ifdef BCD_SUB_EN
        bus.i_op  = op;
`else
        if (op) $display("note: op ignored in add-only build");
        else    bus.i_cin = cin;
`endif
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int lat;
        @(negedge clk);
        drive(v.x, v.y, v.cin, v.op);
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) check($sformatf("v%0d busy", id), 32'(bus.o_busy), 32'd1);
            if (bus.o_done === 1'b1) begin
                lat = n;
                check($sformatf("v%0d S", id), 32'(bus.o_s), 32'(v.s));
                check($sformatf("v%0d cout", id), 32'(bus.o_cout), 32'(v.cout));
                check($sformatf("v%0d err", id), 32'(bus.o_err), 32'(v.err));
                break;
            end
        end
        check($sformatf("v%0d latency", id), 32'(lat), 32'(v.lat));
        @(negedge clk);
        check($sformatf("v%0d done pulse", id), 32'(bus.o_done), 32'd0);
        check($sformatf("v%0d idle", id), 32'(bus.o_busy), 32'd0);
        check($sformatf("v%0d S hold", id), 32'(bus.o_s), 32'(v.s));
    endtask

    initial begin
        int n_done;
        int first_done;
        int second_done;
        logic [15:0] s_at_done;
        logic cout_at_done;

        vecs.push_back(mk(16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 6));
        vecs.push_back(mk(16'h1234, 16'h5678, 1'b1, 1'b0, 16'h6913, 1'b0, 1'b0, 6));
        vecs.push_back(mk(16'h12A4, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 2));
        vecs.push_back(mk(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 6));
        vecs.push_back(mk(16'h4567, 16'h5433, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 6));
        vecs.push_back(mk(16'h0000, 16'h00F0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 2));
        vecs.push_back(mk(16'h2500, 16'h2500, 1'b1, 1'b0, 16'h5001, 1'b0, 1'b0, 6));
        vecs.push_back(mk(16'h9999, 16'h9999, 1'b1, 1'b0, 16'h9999, 1'b1, 1'b0, 6));
        vecs.push_back(mk(16'h0809, 16'h0191, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 6));
`ifdef BCD_SUB_EN
        vecs.push_back(mk(16'h1000, 16'h0001, 1'b0, 1'b1, 16'h0999, 1'b1, 1'b0, 6));
        vecs.push_back(mk(16'h0001, 16'h0002, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0, 6));
        vecs.push_back(mk(16'h0500, 16'h0B00, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 2));
`endif

        rst = 1'b1;
        bus.i_start = 1'b0;
        drive(16'h0000, 16'h0000, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 32'(bus.o_busy), 32'd0);
        check("reset done", 32'(bus.o_done), 32'd0);
        check("reset S",    32'(bus.o_s),    32'd0);
        check("reset cout", 32'(bus.o_cout), 32'd0);
        check("reset err",  32'(bus.o_err),  32'd0);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            run_vec(vecs[i], i);
        end

        // start pulsed during ADD with different operands is ignored
        @(negedge clk);
        drive(16'h1234, 16'h5678, 1'b1, 1'b0);
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        n_done = 0;
        s_at_done = 16'hFFFF;
        cout_at_done = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 3) begin
                drive(16'h9999, 16'h9999, 1'b0, 1'b0);
                bus.i_start = 1'b1;
            end
            if (n == 4) bus.i_start = 1'b0;
            if (bus.o_done === 1'b1) begin
                n_done++;
                s_at_done = bus.o_s;
                cout_at_done = bus.o_cout;
            end
        end
        check("busy-start done count", 32'(n_done), 32'd1);
        check("busy-start S", 32'(s_at_done), 32'h6913);
        check("busy-start cout", 32'(cout_at_done), 32'd0);

        // start held high: back-to-back operations, result cleared on re-accept
        @(negedge clk);
        drive(16'h1234, 16'h5678, 1'b1, 1'b0);
        bus.i_start = 1'b1;
        @(posedge clk);
        first_done = -1;
        second_done = -1;
        for (int n = 1; n <= 18; n++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) begin
                if (first_done < 0) first_done = n;
                else                second_done = n;
            end
            if (n == 7) check("held idle gap", 32'(bus.o_busy), 32'd0);
            if (n == 8) check("held S cleared", 32'(bus.o_s), 32'd0);
            if (n == 14) bus.i_start = 1'b0;
        end
        check("held first done", 32'(first_done), 32'd6);
        check("held second done", 32'(second_done), 32'd13);

        // reset in the second ADD cycle abandons the operation
        @(negedge clk);
        drive(16'h1234, 16'h5678, 1'b1, 1'b0);
        bus.i_start = 1'b1;
        @(posedge clk);
        #1 bus.i_start = 1'b0;
        repeat (3) @(negedge clk);
        check("mid-op partial S", 32'(bus.o_s), 32'h0003);
        rst = 1'b1;
        @(negedge clk);
        check("mid-rst busy", 32'(bus.o_busy), 32'd0);
        check("mid-rst done", 32'(bus.o_done), 32'd0);
        check("mid-rst S",    32'(bus.o_s),    32'd0);
        check("mid-rst cout", 32'(bus.o_cout), 32'd0);
        check("mid-rst err",  32'(bus.o_err),  32'd0);
        rst = 1'b0;
        n_done = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.o_done === 1'b1) n_done++;
        end
        check("mid-rst no done", 32'(n_done), 32'd0);
        run_vec(vecs[1], 100);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
